// File: rtl/wb_stage.sv
// wb_stage: write-back stage holding one retiring instruction between MEM and the register file.
// Optional macro WB_PERF_EN adds retire_cnt/stall_cnt performance counters.
module wb_stage #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_y,
  input  logic [RA_W-1:0] in_rc,
  input  logic            in_we,
  input  logic [1:0]      in_wd_sel,
  input  logic            flush,
  input  logic            mem_rd_valid,
  input  logic [XLEN-1:0] mem_rd,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            byp_valid,
  output logic            byp_pending,
  output logic [RA_W-1:0] byp_wa,
  output logic [XLEN-1:0] byp_wd
`ifdef WB_PERF_EN
  ,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_READY    = 2'd1,
    S_WAIT_MEM = 2'd2
  } state_t;

  localparam logic [RA_W-1:0] ZERO_RC = RA_W'(ZERO_REG);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, y_q, y_d;
  logic [RA_W-1:0] rc_q, rc_d;
  logic            we_q, we_d;
  logic [1:0]      sel_q, sel_d;

  logic            commit, accept, wr_ok, wr_fire;
  logic [XLEN-1:0] wd_mux;

  always_comb begin
    commit   = (state_q == S_READY) || ((state_q == S_WAIT_MEM) && mem_rd_valid);
    // in_ready is held low while rst_n is asserted even though state is already EMPTY.
    in_ready = rst_n && !flush && ((state_q == S_EMPTY) || commit);
    accept   = in_valid && in_ready;
    wr_ok    = we_q && (rc_q != ZERO_RC) && (sel_q != 2'd3);
    wr_fire  = commit && wr_ok && !flush;

    case (sel_q)
      2'd0:    wd_mux = pc_q;
      2'd1:    wd_mux = y_q;
      2'd2:    wd_mux = mem_rd;
      default: wd_mux = '0;
    endcase

    rf_we       = wr_fire;
    rf_wa       = wr_fire ? rc_q : '0;
    rf_wd       = wr_fire ? wd_mux : '0;
    byp_valid   = wr_fire;
    byp_wd      = rf_wd;
    byp_wa      = (state_q != S_EMPTY) ? rc_q : '0;
    byp_pending = (state_q == S_WAIT_MEM) && !mem_rd_valid && we_q &&
                  (rc_q != ZERO_RC) && !flush;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    y_d     = y_q;
    rc_d    = rc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      state_d = (in_wd_sel == 2'd2) ? S_WAIT_MEM : S_READY;
      pc_d    = in_pc;
      y_d     = in_y;
      rc_d    = in_rc;
      we_d    = in_we;
      sel_d   = in_wd_sel;
    end else if (commit) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      pc_q    <= '0;
      y_q     <= '0;
      rc_q    <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      y_q     <= y_d;
      rc_q    <= rc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
    end
  end

`ifdef WB_PERF_EN
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q + CNT_W'(commit && !flush);
    stall_cnt_d  = stall_cnt_q + CNT_W'((state_q == S_WAIT_MEM) && !mem_rd_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`else
  // CNT_W stays in the parameter list so both builds share one interface.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reference model of the held instruction plus literal checks.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_y = '0;
  logic [4:0]  in_rc = '0;
  logic        in_we = 1'b0;
  logic [1:0]  in_wd_sel = '0;
  logic        flush = 1'b0;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rd = '0;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        byp_valid;
  logic        byp_pending;
  logic [4:0]  byp_wa;
  logic [31:0] byp_wd;
`ifdef WB_PERF_EN
  logic [31:0] retire_cnt;
  logic [31:0] stall_cnt;
`endif

  wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_y         (in_y),
    .in_rc        (in_rc),
    .in_we        (in_we),
    .in_wd_sel    (in_wd_sel),
    .flush        (flush),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd       (mem_rd),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .byp_valid    (byp_valid),
    .byp_pending  (byp_pending),
    .byp_wa       (byp_wa),
    .byp_wd       (byp_wd)
`ifdef WB_PERF_EN
    ,
    .retire_cnt   (retire_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] y;
    logic [4:0]  rc;
    logic        we;
    logic [1:0]  sel;
  } instr_t;

  instr_t      held = '0;
  bit          occ = 1'b0;
  int unsigned m_retire = 0;
  int unsigned m_stall = 0;

  function automatic bit is_waiting();
    return occ && (held.sel == 2'd2) && !mem_rd_valid;
  endfunction

  function automatic bit is_retiring();
    return occ && !is_waiting();
  endfunction

  function automatic bit writes_rf(input instr_t i);
    return i.we && (i.rc != 5'd31) && (i.sel != 2'd3);
  endfunction

  function automatic logic [31:0] result_of(input instr_t i, input logic [31:0] mem);
    if (i.sel == 2'd0) return i.pc;
    if (i.sel == 2'd1) return i.y;
    if (i.sel == 2'd2) return mem;
    return 32'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 1'b0;
      held     <= '0;
      m_retire <= 0;
      m_stall  <= 0;
    end else begin
      if (is_waiting()) m_stall <= m_stall + 1;
      if (flush) begin
        occ <= 1'b0;
      end else begin
        if (is_retiring()) m_retire <= m_retire + 1;
        if (in_valid && (!occ || is_retiring())) begin
          occ  <= 1'b1;
          held <= '{pc: in_pc, y: in_y, rc: in_rc, we: in_we, sel: in_wd_sel};
        end else if (is_retiring()) begin
          occ <= 1'b0;
        end
      end
    end
  end

  // Compare every cycle against the model, mid-low-phase when all inputs are stable.
  always @(negedge clk) begin
    automatic bit          live  = rst_n && !flush;
    automatic bit          e_we  = live && is_retiring() && writes_rf(held);
    automatic logic [31:0] e_wd  = e_we ? result_of(held, mem_rd) : 32'd0;
    automatic logic [4:0]  e_wa  = e_we ? held.rc : 5'd0;
    automatic bit          e_rdy = live && (!occ || is_retiring());
    automatic bit          e_pnd = live && is_waiting() && held.we && (held.rc != 5'd31);
    chk("m_in_ready", 32'(in_ready), 32'(e_rdy));
    chk("m_rf_we", 32'(rf_we), 32'(e_we));
    chk("m_rf_wa", 32'(rf_wa), 32'(e_wa));
    chk("m_rf_wd", rf_wd, e_wd);
    chk("m_byp_valid", 32'(byp_valid), 32'(e_we));
    chk("m_byp_pending", 32'(byp_pending), 32'(e_pnd));
    chk("m_byp_wa", 32'(byp_wa), occ ? 32'(held.rc) : 32'd0);
    chk("m_byp_wd", byp_wd, e_wd);
`ifdef WB_PERF_EN
    chk("m_retire_cnt", retire_cnt, m_retire);
    chk("m_stall_cnt", stall_cnt, m_stall);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    flush        = 1'b0;
    mem_rd_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rc, input logic [1:0] sel, input logic [31:0] pc,
                       input logic [31:0] y, input logic we);
    in_valid  = 1'b1;
    in_rc     = rc;
    in_wd_sel = sel;
    in_pc     = pc;
    in_y      = y;
    in_we     = we;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    neg();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_byp_wa", 32'(byp_wa), 32'd0);
    cyc();
    rst_n = 1'b1;
    neg();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // ALU stream
    cyc(); issue(5'd1, 2'd1, 32'h4, 32'h11, 1'b1);
    cyc(); issue(5'd2, 2'd1, 32'h8, 32'h22, 1'b1);
    neg();
    chk("alu0_wa", 32'(rf_wa), 32'd1);
    chk("alu0_wd", rf_wd, 32'h11);
    chk("alu0_rdy", 32'(in_ready), 32'd1);
    cyc(); issue(5'd3, 2'd1, 32'hC, 32'h33, 1'b1);
    neg();
    chk("alu1_wa", 32'(rf_wa), 32'd2);
    chk("alu1_wd", rf_wd, 32'h22);
    cyc(); idle();
    neg();
    chk("alu2_we", 32'(rf_we), 32'd1);
    chk("alu2_wa", 32'(rf_wa), 32'd3);
    chk("alu2_wd", rf_wd, 32'h33);

    // Load with 4-cycle latency; next instruction accepted on the commit edge
    cyc(); issue(5'd5, 2'd2, 32'h10, 32'h0, 1'b1);
    cyc(); idle();
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("ld_wait_rdy", 32'(in_ready), 32'd0);
      chk("ld_wait_pnd", 32'(byp_pending), 32'd1);
      cyc();
    end
    mem_rd_valid = 1'b1;
    mem_rd       = 32'hDEADBEEF;
    issue(5'd6, 2'd1, 32'h14, 32'h66, 1'b1);
    neg();
    chk("ld_we", 32'(rf_we), 32'd1);
    chk("ld_wa", 32'(rf_wa), 32'd5);
    chk("ld_wd", rf_wd, 32'hDEADBEEF);
    chk("ld_rdy", 32'(in_ready), 32'd1);
`ifdef WB_PERF_EN
    chk("ld_stall_cnt", stall_cnt, 32'd3);
`endif
    cyc(); idle();
    neg();
    chk("ld_next_wa", 32'(rf_wa), 32'd6);
    chk("ld_next_wd", rf_wd, 32'h66);

    // R31 branch link is suppressed, R28 link is written
    cyc(); issue(5'd31, 2'd0, 32'h100, 32'h0, 1'b1);
    cyc(); issue(5'd28, 2'd0, 32'h104, 32'h0, 1'b1);
    neg();
    chk("r31_we", 32'(rf_we), 32'd0);
    chk("r31_rdy", 32'(in_ready), 32'd1);
    cyc(); idle();
    neg();
    chk("r28_we", 32'(rf_we), 32'd1);
    chk("r28_wa", 32'(rf_wa), 32'd28);
    chk("r28_wd", rf_wd, 32'h104);
    cyc();
`ifdef WB_PERF_EN
    neg();
    chk("retire_total", retire_cnt, 32'd7);
`endif

    // Flush coincident with load data
    cyc(); issue(5'd7, 2'd2, 32'h200, 32'h0, 1'b1);
    cyc(); idle();
    neg();
    chk("fl_pnd", 32'(byp_pending), 32'd1);
    cyc();
    flush        = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rd       = 32'h77;
    neg();
    chk("fl_we", 32'(rf_we), 32'd0);
    chk("fl_rdy", 32'(in_ready), 32'd0);
    chk("fl_bv", 32'(byp_valid), 32'd0);
    cyc();
    flush = 1'b0;
    neg();
    chk("fl_late_we", 32'(rf_we), 32'd0);
    chk("fl_late_rdy", 32'(in_ready), 32'd1);
    chk("fl_late_bwa", 32'(byp_wa), 32'd0);
    cyc(); idle();

    // Asynchronous reset while waiting on a load
    cyc(); issue(5'd9, 2'd2, 32'h300, 32'h0, 1'b1);
    cyc(); idle();
    neg();
    chk("ar_pnd_before", 32'(byp_pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pnd", 32'(byp_pending), 32'd0);
    chk("ar_rdy", 32'(in_ready), 32'd0);
    chk("ar_bwa", 32'(byp_wa), 32'd0);
    cyc();
    rst_n        = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rd       = 32'h99;
    neg();
    chk("ar_rel_rdy", 32'(in_ready), 32'd1);
    chk("ar_rel_pnd", 32'(byp_pending), 32'd0);
    chk("ar_rel_we", 32'(rf_we), 32'd0);
`ifdef WB_PERF_EN
    chk("ar_retire", retire_cnt, 32'd0);
    chk("ar_stall", stall_cnt, 32'd0);
`endif
    cyc(); idle();

    // Reserved select retires in one cycle without writing
    cyc(); issue(5'd4, 2'd3, 32'h400, 32'h44, 1'b1);
    cyc(); idle();
    neg();
    chk("rsv_we", 32'(rf_we), 32'd0);
    chk("rsv_wa", 32'(rf_wa), 32'd0);
    chk("rsv_wd", rf_wd, 32'd0);
    chk("rsv_rdy", 32'(in_ready), 32'd1);
    cyc();
    neg();
    chk("rsv_gone_bwa", 32'(byp_wa), 32'd0);

    // we=0 load-free instruction
    cyc(); issue(5'd12, 2'd1, 32'h500, 32'h55, 1'b0);
    cyc(); idle();
    neg();
    chk("nowe_we", 32'(rf_we), 32'd0);
    chk("nowe_bwa", 32'(byp_wa), 32'd12);
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
